word_entry_buffer: RTL and testbench

Upstream feeder for the letter-row drawing datapath. Accepts ASCII key strobes from the keyboard decoder and maintains the ten letter slots and the cursor (letter_num). It issues one redraw request per effective edit and holds further edits until the datapath reports done. Keys arriving during a redraw go into a single-entry pending buffer. A full word is submitted on Enter.

---
 rtl/word_entry_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_word_entry_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_entry_buffer.sv
// Keyboard-side front end for the letter-row renderer: holds the ten letter slots and cursor,
// issues one redraw per effective edit and parks at most one key while a redraw is in flight.
module word_entry_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        draw_done,
  output logic [7:0]  first_letter,
  output logic [7:0]  second_letter,
  output logic [7:0]  third_letter,
  output logic [7:0]  fourth_letter,
  output logic [7:0]  fifth_letter,
  output logic [7:0]  sixth_letter,
  output logic [7:0]  seventh_letter,
  output logic [7:0]  eighth_letter,
  output logic [7:0]  ninth_letter,
  output logic [7:0]  tenth_letter,
  output logic [3:0]  letter_num,
  output logic        draw_start,
  output logic        word_submit,
  output logic [79:0] word_out,
  output logic        busy,
  output logic        overflow
);

  localparam int         NUM_LETTERS = 10;
  localparam logic [3:0] CUR_FULL    = 4'd10;
  localparam logic [7:0] BLANK       = 8'h20;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_APPLY,
    ST_DRAW,
    ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  slots_q [NUM_LETTERS];
  logic [7:0]  slots_d [NUM_LETTERS];
  logic [3:0]  cur_q, cur_d;
  logic [79:0] word_out_q, word_out_d;
  logic        draw_start_q, draw_start_d;
  logic        word_submit_q, word_submit_d;
  logic        overflow_q, overflow_d;
  logic        busy_q;

  logic        is_upper, is_lower, is_letter, is_bksp, is_enter;
  logic [7:0]  up_code;
  logic [79:0] slots_flat;
  logic        consume;
  logic        key_direct;

  assign is_upper  = (key_q >= 8'h41) && (key_q <= 8'h5A);
  assign is_lower  = (key_q >= 8'h61) && (key_q <= 8'h7A);
  assign is_letter = is_upper || is_lower;
  assign is_bksp   = (key_q == 8'h08);
  assign is_enter  = (key_q == 8'h0D);
  assign up_code   = is_lower ? (key_q - 8'h20) : key_q;

  always_comb begin
    slots_flat = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      slots_flat[i*8 +: 8] = slots_q[i];
    end
  end

  // A key goes straight to key_q only when idle with nothing parked; otherwise it queues.
  assign key_direct = (state_q == ST_IDLE) && !pend_vld_q;

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    pend_vld_d    = pend_vld_q;
    pend_d        = pend_q;
    slots_d       = slots_q;
    cur_d         = cur_q;
    word_out_d    = word_out_q;
    draw_start_d  = 1'b0;
    word_submit_d = 1'b0;
    overflow_d    = overflow_q;
    consume       = 1'b0;

    case (state_q)
      ST_INIT: begin
        state_d      = ST_DRAW;
        draw_start_d = 1'b1;
      end
      ST_IDLE: begin
        // A key parked on the same edge we dropped into IDLE still has to be served.
        if (pend_vld_q) begin
          key_d   = pend_q;
          consume = 1'b1;
          state_d = ST_APPLY;
        end else if (key_valid) begin
          key_d   = key_code;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (is_letter && (cur_q < CUR_FULL)) begin
          slots_d[cur_q] = up_code;
          cur_d          = cur_q + 4'd1;
          state_d        = ST_DRAW;
          draw_start_d   = 1'b1;
        end else if (is_bksp && (cur_q != 4'd0)) begin
          slots_d[cur_q - 4'd1] = BLANK;
          cur_d                 = cur_q - 4'd1;
          state_d               = ST_DRAW;
          draw_start_d          = 1'b1;
        end else if (is_enter && (cur_q == CUR_FULL)) begin
          word_out_d = slots_flat;
          for (int i = 0; i < NUM_LETTERS; i++) begin
            slots_d[i] = BLANK;
          end
          cur_d         = 4'd0;
          state_d       = ST_DRAW;
          draw_start_d  = 1'b1;
          word_submit_d = 1'b1;
        end else if (pend_vld_q) begin
          key_d   = pend_q;
          consume = 1'b1;
          state_d = ST_APPLY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (draw_done) begin
          if (pend_vld_q) begin
            key_d   = pend_q;
            consume = 1'b1;
            state_d = ST_APPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (key_valid && !key_direct) begin
      if (!pend_vld_q || consume) begin
        pend_d     = key_code;
        pend_vld_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (consume) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_INIT;
      key_q         <= '0;
      pend_vld_q    <= 1'b0;
      pend_q        <= '0;
      for (int i = 0; i < NUM_LETTERS; i++) begin
        slots_q[i] <= BLANK;
      end
      cur_q         <= '0;
      word_out_q    <= '0;
      draw_start_q  <= 1'b0;
      word_submit_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      pend_vld_q    <= pend_vld_d;
      pend_q        <= pend_d;
      slots_q       <= slots_d;
      cur_q         <= cur_d;
      word_out_q    <= word_out_d;
      draw_start_q  <= draw_start_d;
      word_submit_q <= word_submit_d;
      overflow_q    <= overflow_d;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign first_letter   = slots_q[0];
  assign second_letter  = slots_q[1];
  assign third_letter   = slots_q[2];
  assign fourth_letter  = slots_q[3];
  assign fifth_letter   = slots_q[4];
  assign sixth_letter   = slots_q[5];
  assign seventh_letter = slots_q[6];
  assign eighth_letter  = slots_q[7];
  assign ninth_letter   = slots_q[8];
  assign tenth_letter   = slots_q[9];
  assign letter_num     = cur_q;
  assign draw_start     = draw_start_q;
  assign word_submit    = word_submit_q;
  assign word_out       = word_out_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_word_entry_buffer.sv
// Directed bench for word_entry_buffer: inputs driven and outputs sampled on the falling edge.
module tb_word_entry_buffer;

  logic        clock;
  logic        reset;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        draw_done;
  logic [7:0]  l0, l1, l2, l3, l4, l5, l6, l7, l8, l9;
  logic [3:0]  letter_num;
  logic        draw_start;
  logic        word_submit;
  logic [79:0] word_out;
  logic        busy;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int ds_cnt  = 0;
  int ws_cnt  = 0;

  word_entry_buffer dut (
    .clock         (clock),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .draw_done     (draw_done),
    .first_letter  (l0),
    .second_letter (l1),
    .third_letter  (l2),
    .fourth_letter (l3),
    .fifth_letter  (l4),
    .sixth_letter  (l5),
    .seventh_letter(l6),
    .eighth_letter (l7),
    .ninth_letter  (l8),
    .tenth_letter  (l9),
    .letter_num    (letter_num),
    .draw_start    (draw_start),
    .word_submit   (word_submit),
    .word_out      (word_out),
    .busy          (busy),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (draw_start === 1'b1) ds_cnt++;
    if (word_submit === 1'b1) ws_cnt++;
  endtask

  task automatic done_pulse();
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
  endtask

  // Press one key from IDLE; leaves the FSM back in IDLE.
  task automatic type_key(input logic [7:0] code, input logic exp_draw);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    step();
    check($sformatf("draw_%0h", code), {79'd0, draw_start}, {79'd0, exp_draw});
    if (exp_draw) begin
      step();
      done_pulse();
    end
  endtask

  logic [79:0] exp_word;
  int          busy_low;
  int          ds0;

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    draw_done = 1'b0;
    repeat (3) step();

    check("rst_first",  {72'd0, l0}, 80'h20);
    check("rst_tenth",  {72'd0, l9}, 80'h20);
    check("rst_cursor", {76'd0, letter_num}, 80'd0);
    check("rst_busy",   {79'd0, busy}, 80'd1);
    check("rst_ovf",    {79'd0, overflow}, 80'd0);
    check("rst_ds",     {79'd0, draw_start}, 80'd0);
    check("rst_wout",   word_out, 80'd0);

    // Power-up frame: one draw pulse, then WAIT until draw_done.
    reset  = 1'b0;
    ds_cnt = 0;
    step();
    check("init_ds", {79'd0, draw_start}, 80'd1);
    busy_low = 0;
    repeat (50) begin
      step();
      if (busy !== 1'b1) busy_low++;
    end
    check("init_busy_held", busy_low, 0);
    check("init_ds_count", ds_cnt, 1);
    done_pulse();
    check("init_idle", {79'd0, busy}, 80'd0);

    // Backspace with empty word is ignored.
    type_key(8'h08, 1'b0);
    check("bs0_idle", {79'd0, busy}, 80'd0);
    check("bs0_cursor", {76'd0, letter_num}, 80'd0);

    // 'h','i' with draw_done five cycles after each draw_start.
    ds0 = ds_cnt;
    for (int k = 0; k < 2; k++) begin
      key_valid = 1'b1;
      key_code  = (k == 0) ? 8'h68 : 8'h69;
      step();
      key_valid = 1'b0;
      step();
      check("hi_ds", {79'd0, draw_start}, 80'd1);
      repeat (5) step();
      done_pulse();
    end
    check("hi_first",  {72'd0, l0}, 80'h48);
    check("hi_second", {72'd0, l1}, 80'h49);
    check("hi_cursor", {76'd0, letter_num}, 80'd2);
    check("hi_ds_count", ds_cnt - ds0, 2);

    // Clear, type AB, then backspace.
    type_key(8'h08, 1'b1);
    type_key(8'h08, 1'b1);
    type_key(8'h41, 1'b1);
    type_key(8'h42, 1'b1);
    type_key(8'h08, 1'b1);
    check("ab_first",  {72'd0, l0}, 80'h41);
    check("ab_second", {72'd0, l1}, 80'h20);
    check("ab_cursor", {76'd0, letter_num}, 80'd1);
    type_key(8'h08, 1'b1);

    // Ten letters (mixed case), 'Z' beyond the end, then Enter.
    exp_word = '0;
    for (int i = 0; i < 10; i++) begin
      type_key((i % 2 == 1) ? 8'(8'h61 + i) : 8'(8'h41 + i), 1'b1);
      exp_word[i*8 +: 8] = 8'(8'h41 + i);
    end
    check("ten_cursor", {76'd0, letter_num}, 80'd10);
    check("ten_last",   {72'd0, l9}, 80'h4A);
    check("ten_seventh", {72'd0, l6}, 80'h47);
    type_key(8'h5A, 1'b0);
    check("z_last", {72'd0, l9}, 80'h4A);
    key_valid = 1'b1;
    key_code  = 8'h0D;
    step();
    key_valid = 1'b0;
    step();
    check("ent_ds",     {79'd0, draw_start}, 80'd1);
    check("ent_submit", {79'd0, word_submit}, 80'd1);
    check("ent_word",   word_out, exp_word);
    check("ent_first",  {72'd0, l0}, 80'h20);
    check("ent_tenth",  {72'd0, l9}, 80'h20);
    check("ent_cursor", {76'd0, letter_num}, 80'd0);
    step();
    check("ent_submit_off", {79'd0, word_submit}, 80'd0);
    done_pulse();
    check("ent_ws_count", ws_cnt, 1);

    // Burst A,B,C on consecutive cycles with draw_done low.
    key_valid = 1'b1;
    key_code  = 8'h41;
    step();
    key_code  = 8'h42;
    step();
    key_code  = 8'h43;
    step();
    key_valid = 1'b0;
    check("burst_ovf",    {79'd0, overflow}, 80'd1);
    check("burst_cursor", {76'd0, letter_num}, 80'd1);
    repeat (3) step();
    done_pulse();
    step();
    check("burst_ds",     {79'd0, draw_start}, 80'd1);
    check("burst_second", {72'd0, l1}, 80'h42);
    check("burst_third",  {72'd0, l2}, 80'h20);
    check("burst_cursor2", {76'd0, letter_num}, 80'd2);
    step();

    // Park a key during WAIT, then reset: everything, including the parked key, is lost.
    key_valid = 1'b1;
    key_code  = 8'h44;
    step();
    key_valid = 1'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_ovf",    {79'd0, overflow}, 80'd0);
    check("mrst_cursor", {76'd0, letter_num}, 80'd0);
    check("mrst_first",  {72'd0, l0}, 80'h20);
    check("mrst_busy",   {79'd0, busy}, 80'd1);
    step();
    check("mrst_ds", {79'd0, draw_start}, 80'd1);
    step();
    done_pulse();
    repeat (3) step();
    check("mrst_idle",    {79'd0, busy}, 80'd0);
    check("mrst_cursor2", {76'd0, letter_num}, 80'd0);

    // New key in WAIT on the same edge draw_done consumes a full pending slot.
    key_valid = 1'b1;
    key_code  = 8'h4B;
    step();
    key_code  = 8'h4C;
    step();
    key_valid = 1'b0;
    step();
    key_valid = 1'b1;
    key_code  = 8'h4D;
    draw_done = 1'b1;
    step();
    key_valid = 1'b0;
    draw_done = 1'b0;
    check("race_ovf",    {79'd0, overflow}, 80'd0);
    check("race_cursor", {76'd0, letter_num}, 80'd1);
    step();
    check("race_ds",     {79'd0, draw_start}, 80'd1);
    check("race_second", {72'd0, l1}, 80'h4C);
    step();
    done_pulse();
    step();
    check("race_third",   {72'd0, l2}, 80'h4D);
    check("race_cursor2", {76'd0, letter_num}, 80'd3);
    check("race_ovf2",    {79'd0, overflow}, 80'd0);
    step();
    done_pulse();
    check("race_idle", {79'd0, busy}, 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
